// File: rtl/spi_pkg.sv
// spi_pkg: types, frame lengths and edge selection shared by the
// SPI leader controller and the SPI follower.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE,
    WAIT_CS
  } state_t;

  localparam int LEN8  = 8;
  localparam int LEN16 = 16;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic len16;
    logic lsb;
  } cfg_t;

  // 1: sample on the rising sclk edge, shift on falling; 0: opposite.
  function automatic logic spi_sample_rise(
    input logic cpol,
    input logic cpha
  );
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-flop synchroniser with rise/fall pulses taken
// from the last two synchronised samples.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end

  assign q    = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_follower.sv
// spi_follower: SPI target endpoint, all inputs synchronised to clk.
// Define SPI_FOLLOWER_LSB_FIRST_EN to add the cfg_lsb_first port.
module spi_follower
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_len16,
`ifdef SPI_FOLLOWER_LSB_FIRST_EN
  input  logic              cfg_lsb_first,
`endif
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              underrun,
  output logic              overrun,
  output logic              frame_err
);

  localparam int IW = $clog2(DATA_W);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_s;

  state_t state_q, state_d;
  cfg_t   cfg_q, cfg_d;

  logic [DATA_W-1:0] hold_q, tx_sr, tx_nx;
  logic [DATA_W-1:0] rx_sr, rx_nx, rx_q;
  logic              hold_full, rx_vld, armed;
  logic [4:0]        cnt, len_cnt;
  logic [IW-1:0]     msb;
  logic              start, abort, act;
  logic              samp_lvl, sclk_evt, samp_ev, shift_ev;
  logic              tx_bit;
  logic              unr_q, ovr_q, ferr_q;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sclk (
    .clk (clk),
    .rst_n(rst_n),
    .d   (sclk_in),
    .q   (sclk_s),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk (clk),
    .rst_n(rst_n),
    .d   (cs_n_in),
    .q   (cs_s),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sr <= '0;
    else        mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  always_comb begin
    cfg_d.cpol  = cfg_cpol;
    cfg_d.cpha  = cfg_cpha;
    cfg_d.len16 = cfg_len16;
`ifdef SPI_FOLLOWER_LSB_FIRST_EN
    cfg_d.lsb   = cfg_lsb_first;
`else
    cfg_d.lsb   = 1'b0;
`endif
  end

  assign len_cnt  = cfg_q.len16 ? 5'(LEN16) : 5'(LEN8);
  assign msb      = cfg_q.len16 ? IW'(LEN16 - 1) : IW'(LEN8 - 1);
  assign act      = (state_q == ACTIVE) && (cnt != len_cnt);
  assign samp_lvl = spi_sample_rise(cfg_q.cpol, cfg_q.cpha);
  assign sclk_evt = sclk_rise | sclk_fall;
  // The new sclk level tells which of the two edges just occurred.
  assign samp_ev  = act & sclk_evt & (sclk_s == samp_lvl);
  assign shift_ev = act & sclk_evt & (sclk_s != samp_lvl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cnt == len_cnt) begin
          state_d = DONE;
        end else if (cs_rise) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      DONE:    state_d = WAIT_CS;
      WAIT_CS: if (cs_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_nx    = rx_sr << 1;
    rx_nx[0] = mosi_s;
    tx_nx    = tx_sr << 1;
    tx_bit   = tx_sr[msb];
    if (cfg_q.lsb) begin
      rx_nx      = rx_sr >> 1;
      rx_nx[msb] = mosi_s;
      tx_nx      = tx_sr >> 1;
      tx_bit     = tx_sr[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      tx_sr     <= '1;
      rx_sr     <= '0;
      rx_q      <= '0;
      rx_vld    <= 1'b0;
      cnt       <= '0;
      armed     <= 1'b0;
      unr_q     <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      unr_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ferr_q <= abort;
      if (tx_valid && !hold_full) begin
        hold_q    <= tx_data;
        hold_full <= 1'b1;
      end
      if (start) begin
        cfg_q <= cfg_d;
        cnt   <= '0;
        rx_sr <= '0;
        // With cpha=1 the first leading edge presents bit 0 of the frame.
        armed <= ~cfg_cpha;
        if (hold_full) begin
          tx_sr     <= hold_q;
          hold_full <= 1'b0;
        end else begin
          tx_sr <= '1;
          unr_q <= 1'b1;
        end
      end else begin
        if (samp_ev) begin
          rx_sr <= rx_nx;
          cnt   <= cnt + 5'd1;
        end
        if (shift_ev) begin
          if (armed) tx_sr <= tx_nx;
          armed <= 1'b1;
        end
      end
      if (state_q == DONE) begin
        if (rx_vld && !rx_ready) begin
          ovr_q <= 1'b1;
        end else begin
          rx_q   <= rx_sr;
          rx_vld <= 1'b1;
        end
      end else if (rx_vld && rx_ready) begin
        rx_vld <= 1'b0;
      end
    end
  end

  assign miso      = ((state_q != IDLE) && armed) ? tx_bit : 1'b1;
  assign miso_oe   = ~cs_s;
  assign tx_ready  = ~hold_full;
  assign rx_data   = rx_q;
  assign rx_valid  = rx_vld;
  assign underrun  = unr_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_follower.sv
// tb_spi_follower: directed leader-side transfers with immediate
// assertions against hand-computed words and pulse counts.
module tb_spi_follower;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk_in = 1'b0;
  logic        cs_n_in = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe;
  logic        cfg_cpol = 1'b0;
  logic        cfg_cpha = 1'b0;
  logic        cfg_len16 = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        underrun, overrun, frame_err;

  int total = 0;
  int bad = 0;
  int n_unr = 0;
  int n_ovr = 0;
  int n_ferr = 0;
  int u0, o0, f0;
  logic [15:0] mi;
  bit unst;

  always #5 clk = ~clk;

  spi_follower #(
    .SYNC_STAGES(2),
    .DATA_W     (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk_in  (sclk_in),
    .cs_n_in  (cs_n_in),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .cfg_cpol (cfg_cpol),
    .cfg_cpha (cfg_cpha),
    .cfg_len16(cfg_len16),
`ifdef SPI_FOLLOWER_LSB_FIRST_EN
    .cfg_lsb_first(1'b0),
`endif
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .underrun (underrun),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always @(posedge clk) begin
    if (underrun)  n_unr  <= n_unr + 1;
    if (overrun)   n_ovr  <= n_ovr + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [15:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  // Leader model: mi collects MISO at each sample edge; unst flags a
  // MISO change in the clk cycle just before a sample edge.
  task automatic xfer(input bit cpol, input bit cpha, input bit len16,
                      input logic [15:0] mo, input int nbits,
                      input bit keep_cs, input int h,
                      output logic [15:0] mi_o, output bit unst_o);
    int   w;
    logic prev;
    w = len16 ? 16 : 8;
    mi_o = '0;
    unst_o = 1'b0;
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    cfg_len16 = len16;
    sclk_in = cpol;
    wait_clks(6);
    cs_n_in = 1'b0;
    if (!cpha) mosi = mo[w-1];
    wait_clks(8);
    for (int i = 0; i < nbits; i++) begin
      wait_clks(h - 1);
      prev = miso;
      wait_clks(1);
      if (!cpha) begin
        mi_o = {mi_o[14:0], miso};
        if (miso !== prev) unst_o = 1'b1;
      end
      sclk_in = ~cpol;
      if (cpha) mosi = mo[w-1-i];
      wait_clks(h - 1);
      prev = miso;
      wait_clks(1);
      if (cpha) begin
        mi_o = {mi_o[14:0], miso};
        if (miso !== prev) unst_o = 1'b1;
      end
      sclk_in = cpol;
      if (!cpha && i < w - 1) mosi = mo[w-2-i];
    end
    wait_clks(h);
    if (!keep_cs) begin
      cs_n_in = 1'b1;
      wait_clks(8);
    end
  endtask

  initial begin
    wait_clks(3);
    chk("rst_miso", 32'(miso), 1);
    chk("rst_oe", 32'(miso_oe), 0);
    chk("rst_txrdy", 32'(tx_ready), 1);
    chk("rst_rxvld", 32'(rx_valid), 0);
    chk("rst_rxdata", 32'(rx_data), 0);
    chk("rst_pulses", {29'd0, underrun, overrun, frame_err}, 0);
    rst_n = 1'b1;
    wait_clks(4);

    // Mode 0, 8-bit, clk/8
    load_tx(16'h00A5);
    chk("m0_txrdy_lo", 32'(tx_ready), 0);
    u0 = n_unr;
    xfer(1'b0, 1'b0, 1'b0, 16'h003C, 8, 1'b0, 4, mi, unst);
    chk("m0_miso", 32'(mi), 'hA5);
    chk("m0_stable", 32'(unst), 0);
    chk("m0_rx", 32'(rx_data), 'h3C);
    chk("m0_rxvld", 32'(rx_valid), 1);
    chk("m0_txrdy", 32'(tx_ready), 1);
    chk("m0_nounr", n_unr - u0, 0);
    consume();
    chk("m0_rx_clr", 32'(rx_valid), 0);

    // Mode 3, 16-bit
    load_tx(16'h1234);
    xfer(1'b1, 1'b1, 1'b1, 16'hBEEF, 16, 1'b0, 6, mi, unst);
    chk("m3_miso", 32'(mi), 'h1234);
    chk("m3_stable", 32'(unst), 0);
    chk("m3_rx", 32'(rx_data), 'hBEEF);
    chk("m3_rxvld", 32'(rx_valid), 1);
    consume();

    // Mode 1, no tx word
    u0 = n_unr;
    xfer(1'b0, 1'b1, 1'b0, 16'h0096, 8, 1'b0, 6, mi, unst);
    chk("m1_unr", n_unr - u0, 1);
    chk("m1_miso", 32'(mi), 'hFF);
    chk("m1_rx", 32'(rx_data), 'h96);
    consume();

    // Back-to-back frames without consuming
    o0 = n_ovr;
    xfer(1'b0, 1'b0, 1'b0, 16'h0011, 8, 1'b0, 4, mi, unst);
    chk("ovr_rx1", 32'(rx_data), 'h11);
    chk("ovr_none", n_ovr - o0, 0);
    xfer(1'b0, 1'b0, 1'b0, 16'h0022, 8, 1'b0, 4, mi, unst);
    chk("ovr_rx2", 32'(rx_data), 'h11);
    chk("ovr_pulse", n_ovr - o0, 1);
    chk("ovr_rxvld", 32'(rx_valid), 1);
    consume();
    chk("ovr_rx_clr", 32'(rx_valid), 0);

    // CS raised after 5 bits, then a clean frame
    f0 = n_ferr;
    xfer(1'b0, 1'b0, 1'b0, 16'h00FF, 5, 1'b0, 4, mi, unst);
    chk("ferr_pulse", n_ferr - f0, 1);
    chk("ferr_rxvld", 32'(rx_valid), 0);
    xfer(1'b0, 1'b0, 1'b0, 16'h005A, 8, 1'b0, 4, mi, unst);
    chk("ferr_rx", 32'(rx_data), 'h5A);
    chk("ferr_rxvld2", 32'(rx_valid), 1);
    chk("ferr_once", n_ferr - f0, 1);

    // Reset mid-frame after 3 bits
    load_tx(16'h00C3);
    xfer(1'b0, 1'b0, 1'b0, 16'h0081, 3, 1'b1, 4, mi, unst);
    chk("rstmid_miso", 32'(mi), 'h6);
    chk("rstmid_oe_hi", 32'(miso_oe), 1);
    load_tx(16'h0099);
    chk("rstmid_txrdy_lo", 32'(tx_ready), 0);
    chk("rstmid_rxvld_hi", 32'(rx_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_oe", 32'(miso_oe), 0);
    chk("rstmid_txrdy", 32'(tx_ready), 1);
    chk("rstmid_rxvld", 32'(rx_valid), 0);
    chk("rstmid_rxdata", 32'(rx_data), 0);
    chk("rstmid_miso1", 32'(miso), 1);
    cs_n_in = 1'b1;
    sclk_in = 1'b0;
    mosi = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    load_tx(16'h003C);
    xfer(1'b0, 1'b0, 1'b0, 16'h00E7, 8, 1'b0, 4, mi, unst);
    chk("post_miso", 32'(mi), 'h3C);
    chk("post_rx", 32'(rx_data), 'hE7);
    chk("post_rxvld", 32'(rx_valid), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_follower.md
Name: spi_follower

Overview:
- Dedicated SPI follower (target) endpoint: receives an externally driven SCLK and chip select, and samples MOSI into a receive word.
- Shifts a CPU-supplied transmit word out on MISO.
- Complements the leader-capable SPI controller. Uses the same config semantics: CPOL, CPHA, 8/16-bit length.
- All external inputs are synchronised into the system clock domain. Shift and sample decisions come from edge detection on the synchronised SCLK.

Parameters:
- SYNC_STAGES, 2, flop depth of the synchronisers on sclk_in, cs_n_in and mosi (minimum 2).
- DATA_W, 16, maximum frame width; an 8-bit frame uses bits [7:0].

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- sclk_in  in  1  SPI clock from the leader (asynchronous)
- cs_n_in  in  1  chip select from the leader, active-low (asynchronous)
- mosi  in  1  serial data from the leader
- miso  out  1  serial data to the leader
- miso_oe  out  1  MISO output enable; high only while the synchronised CS is low
- cfg_cpol  in  1  clock polarity
- cfg_cpha  in  1  clock phase
- cfg_len16  in  1  1 = 16-bit frame, 0 = 8-bit frame
- tx_data  in  DATA_W  next word to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmit holding register is empty
- rx_data  out  DATA_W  last received word, zero-extended for 8-bit frames
- rx_valid  out  1  rx_data holds an unread word
- rx_ready  in  1  CPU consumes rx_data
- underrun  out  1  one-cycle pulse: a frame started with no tx word loaded
- overrun  out  1  one-cycle pulse: a frame completed while rx_valid was still high
- frame_err  out  1  one-cycle pulse: CS deasserted mid-frame

Behaviour:
- Reset values:
  - miso = 1, miso_oe = 0, tx_ready = 1, rx_valid = 0, rx_data = 0.
  - underrun, overrun and frame_err all = 0.
  - FSM in IDLE, bit count = 0.
  - Synchronisers reset to idle levels: cs = 1, sclk = 0.
- Synchronisation and edge detection:
  - All three external inputs pass through SYNC_STAGES flops.
  - sclk edges are detected by comparing the last synced value with the previous one.
  - Requirement: SCLK period >= 8 clk cycles.
- Edge selection (uses config latched at frame start):
  - Leading edge = rising if cpol = 0, else falling.
  - Sample edge = leading if cpha = 0, trailing if cpha = 1.
  - Shift edge = the other edge.
- Transmit handshake:
  - tx word is accepted when tx_valid && tx_ready, into a holding register; tx_ready then drops.
- FSM states:
  - IDLE:
    - On a synced CS falling edge: latch cpol, cpha and len16.
    - If the holding register is full, load it into the tx shift register and set tx_ready = 1 in the next cycle.
    - If it is empty, load all-ones and pulse underrun.
    - Clear the count, then go to ACTIVE.
  - ACTIVE:
    - MISO = MSB of the active width (bit 15 or bit 7).
    - cpha = 0: the first bit is valid from the cycle after CS falls.
    - cpha = 1: the first shift edge is the first leading edge, so MISO updates there.
    - Every sample edge: shift mosi into the rx shift register and increment the 5-bit count.
    - When count reaches 8 or 16, go to DONE.
    - Shift edges after the final sample are ignored.
  - DONE:
    - Transfer the rx shift register to rx_data and set rx_valid.
    - If rx_valid is already high and rx_ready is low: keep the old rx_data, pulse overrun.
    - Return to WAIT_CS.
  - WAIT_CS:
    - Hold MISO. Go to IDLE on a synced CS rising edge.
    - A new frame requires CS to deassert first.
- rx_valid clears on the cycle after rx_valid && rx_ready. It sets again in the same cycle if DONE coincides with that clear; new data wins.
- CS rising while ACTIVE: abort to IDLE, pulse frame_err, no rx_valid. A loaded tx word is discarded; the holding register is unaffected.
- Config changes during a frame are ignored until the next CS falling edge.
- rst_n asserted mid-frame: everything returns to reset values immediately.

Optional Feature:
- Macro SPI_FOLLOWER_LSB_FIRST_EN.
- Defined: adds input port cfg_lsb_first (1 bit), latched at CS fall. When set, bit 0 is shifted first on MISO and received bits fill from the MSB of the active width downward, so rx_data is bit-aligned.
- Undefined: no port; MSB-first only.

Decomposition:
- Shared package spi_pkg:
  - FSM state enum: IDLE, ACTIVE, DONE, WAIT_CS.
  - Constants LEN8 = 8 and LEN16 = 16.
  - Function selecting the sample/shift edge from cpol and cpha; shared with the leader controller.
- Sub-module spi_sync_edge: N-stage synchroniser plus rise/fall pulse outputs. Instantiated for sclk and cs; mosi uses the synchroniser only.

Test Plan:
- Mode 0, 8-bit, tx 0xA5 preloaded; leader sends 0x3C at clk/8 -> MISO bits 1,0,1,0,0,1,0,1; rx_data = 0x003C, rx_valid for 1+ cycles; tx_ready = 1 after CS fall.
- Mode 3, 16-bit, tx 0x1234; leader sends 0xBEEF -> rx_data = 0xBEEF; MISO updates only on falling edges and is stable at each rising edge.
- Mode 1, no tx loaded -> underrun pulse at CS fall; MISO all ones; frame still received.
- Two back-to-back 8-bit frames 0x11 then 0x22, rx_ready held low -> rx_data stays 0x11; overrun pulses once after the second frame.
- CS raised after 5 bits -> frame_err pulse; rx_valid stays 0. A following full frame 0x5A is received correctly.
- rst_n low mid-frame at bit 3 -> miso_oe = 0, tx_ready = 1 and rx_valid = 0 immediately. The next frame after release works.
